// File: rtl/edge_propagator_if.sv
// Bus bundle for edge_propagator: the event input stream, the edge-memory
// read port and the scaled-event output stream.
// The slave view belongs to the propagator; the master view belongs to its
// surroundings: the event source, the edge memory and the downstream queue.
interface edge_propagator_if #(
  parameter int VID_W  = 8,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
);
  logic              evt_valid;
  logic              evt_ready;
  logic [15:0]       evt_delta;
  logic [ADDR_W-1:0] evt_edge_base;
  logic [CNT_W-1:0]  evt_edge_cnt;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [VID_W+15:0] mem_rd_data;

  logic              out_valid;
  logic              out_ready;
  logic [VID_W-1:0]  out_dest;
  logic [15:0]       out_value;

  modport slave (
    input  evt_valid, evt_delta, evt_edge_base, evt_edge_cnt,
    input  mem_rd_data, out_ready,
    output evt_ready, mem_rd_en, mem_rd_addr,
    output out_valid, out_dest, out_value
  );

  modport master (
    output evt_valid, evt_delta, evt_edge_base, evt_edge_cnt,
    output mem_rd_data, out_ready,
    input  evt_ready, mem_rd_en, mem_rd_addr,
    input  out_valid, out_dest, out_value
  );
endinterface

// File: rtl/edge_propagator.sv
// edge_propagator: walks the edge list of one propagation event and emits
// one (destination, delta * weight) event per edge. The file also holds
// the fp16 multiplier that is used inside it.

// fp16 (1/5/10) multiplier. Rounding is to nearest, with ties to even.
// A result that is too small becomes a signed zero. A result that is too
// large becomes a signed infinity.
module fp_mul (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] p
);
  logic        sign;
  logic [4:0]  ea;
  logic [4:0]  eb;
  logic [21:0] prod;
  logic        norm;
  logic [9:0]  mant;
  logic        guard;
  logic        sticky;
  logic [10:0] mant_r;
  logic [6:0]  e_sum;
  logic [6:0]  e_res;
  logic        a_nan;
  logic        b_nan;
  logic        any_zero;

  // Multiply the significands, normalise, round, then handle the special operands
  always_comb begin
    sign     = a[15] ^ b[15];
    ea       = a[14:10];
    eb       = b[14:10];
    a_nan    = (ea == 5'h1f) && (a[9:0] != 10'd0);
    b_nan    = (eb == 5'h1f) && (b[9:0] != 10'd0);
    any_zero = (ea == 5'd0) || (eb == 5'd0);
    prod     = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
    norm     = prod[21];
    if (norm) begin
      mant   = prod[20:11];
      guard  = prod[10];
      sticky = |prod[9:0];
    end else begin
      mant   = prod[19:10];
      guard  = prod[9];
      sticky = |prod[8:0];
    end
    mant_r = {1'b0, mant} + {10'd0, guard & (sticky | mant[0])};
    // When rounding carries out, the fraction wraps to zero and the exponent goes up by one.
    e_sum  = {2'b00, ea} + {2'b00, eb} + {6'd0, norm} + {6'd0, mant_r[10]};
    e_res  = e_sum - 7'd15;
    if (a_nan || b_nan) begin
      p = 16'h7e00;
    end else if (ea == 5'h1f || eb == 5'h1f) begin
      p = any_zero ? 16'h7e00 : {sign, 5'h1f, 10'd0};
    end else if (any_zero) begin
      p = {sign, 15'd0};
    end else if (e_sum >= 7'd46) begin
      p = {sign, 5'h1f, 10'd0};
    end else if (e_sum <= 7'd15) begin
      p = {sign, 15'd0};
    end else begin
      p = {sign, e_res[4:0], mant_r[9:0]};
    end
  end
endmodule

module edge_propagator #(
  parameter int VID_W  = 8,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  edge_propagator_if.slave bus,
  output logic             busy
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

  state_t            state_reg;
  logic [15:0]       delta_reg;
  logic [ADDR_W-1:0] next_addr_reg;
  logic [ADDR_W-1:0] addr_hold_reg;
  logic [CNT_W-1:0]  rem_reg;
  logic              rd_inflight_reg;
  logic              out_valid_reg;
  logic [VID_W-1:0]  out_dest_reg;
  logic [15:0]       out_value_reg;

  logic              issue;
  logic [VID_W-1:0]  dest_id;
  logic [15:0]       weight;
  logic [15:0]       mul_result;
  logic [15:0]       scaled;

  // A read goes out only when its result is sure to have a free output slot.
  // A slot is free if it is empty now, or if it is being drained this cycle.
  assign issue = (state_reg == RUN) && (rem_reg != '0) && !rd_inflight_reg &&
                 (!out_valid_reg || bus.out_ready);

  assign dest_id = bus.mem_rd_data[VID_W+15:16];
  assign weight  = bus.mem_rd_data[15:0];

  fp_mul u_fp_mul (
    .a (delta_reg),
    .b (weight),
    .p (mul_result)
  );

  // A zero or subnormal operand (exponent field 0) forces a signed zero.
  // This takes precedence over whatever the multiplier returns.
  assign scaled = (delta_reg[14:10] == 5'd0 || weight[14:10] == 5'd0) ?
                  {delta_reg[15] ^ weight[15], 15'd0} : mul_result;

  assign bus.evt_ready   = (state_reg == IDLE);
  assign bus.mem_rd_en   = issue;
  assign bus.mem_rd_addr = issue ? next_addr_reg : addr_hold_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_dest    = out_dest_reg;
  assign bus.out_value   = out_value_reg;
  assign busy            = (state_reg == RUN) || rd_inflight_reg;

  // Control FSM with the read-address walk and the registered output slot
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      delta_reg       <= '0;
      next_addr_reg   <= '0;
      addr_hold_reg   <= '0;
      rem_reg         <= '0;
      rd_inflight_reg <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_dest_reg    <= '0;
      out_value_reg   <= '0;
    end else begin
      // Returning read data loads the slot. The issue rule guarantees the slot is free.
      if (rd_inflight_reg) begin
        out_valid_reg <= 1'b1;
        out_dest_reg  <= dest_id;
        out_value_reg <= scaled;
      end else if (out_valid_reg && bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end

      rd_inflight_reg <= issue;
      if (issue) begin
        addr_hold_reg <= next_addr_reg;
        next_addr_reg <= next_addr_reg + ADDR_ONE;
        rem_reg       <= rem_reg - CNT_ONE;
      end

      case (state_reg)
        IDLE: begin
          if (bus.evt_valid) begin
            delta_reg     <= bus.evt_delta;
            next_addr_reg <= bus.evt_edge_base;
            rem_reg       <= bus.evt_edge_cnt;
            if (bus.evt_edge_cnt != '0) begin
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          if (rem_reg == '0 && !rd_inflight_reg) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
